// File: rtl/system_acl_iface_dbnc_pio.sv
// rtl/system_acl_iface_dbnc_pio.sv - debounced parallel input port with edge capture and interrupt
//
// Purpose: synchronizes WIDTH asynchronous inputs, debounces each bit with a
// per-bit stability counter, latches qualified rising/falling edges into a
// write-1-to-clear capture register and raises a level interrupt for unmasked
// captured edges. Registers are reached through a simple Avalon-style slave.
//
// Ports:
//   clk         single clock for all logic
//   reset_n     synchronous active-low reset
//   address     slave word address (0 db, 1 sync_in, 2 irq_mask,
//               3 edge_capture, 4 rise_en, 5 fall_en, 6-7 zero)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, low WIDTH bits used
//   in_port     raw asynchronous inputs
//   readdata    registered read data, one cycle after address
//   irq         OR of (edge_capture & irq_mask)
module system_acl_iface_dbnc_pio #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The change is accepted on the edge where the counter would reach
  // DEBOUNCE_CYCLES, i.e. the DEBOUNCE_CYCLES-th consecutive differing sample.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_nxt;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign sync_in      = sync_q[SYNC_STAGES-1];
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Synchronizer chain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Per-bit debounce: any sample equal to db restarts the stability count,
  // so a glitch shorter than DEBOUNCE_CYCLES can never flip db.
  always_comb begin
    db_nxt = db;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync_in[i] != db[i]) begin
        if (cnt[i] == CNT_LAST) begin
          db_nxt[i] = sync_in[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign cap_set = (db_nxt & ~db & rise_en) | (~db_nxt & db & fall_en);
  assign cap_clr = (wr_en && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux[WIDTH-1:0] = db;
      3'd1:    rd_mux[WIDTH-1:0] = sync_in;
      3'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      3'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      3'd4:    rd_mux[WIDTH-1:0] = rise_en;
      3'd5:    rd_mux[WIDTH-1:0] = fall_en;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db           <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      rise_en      <= '1;
      fall_en      <= '1;
      readdata     <= '0;
    end else begin
      db <= db_nxt;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      // Set is ORed after the clear so a same-cycle set survives the W1C.
      edge_capture <= (edge_capture & ~cap_clr) | cap_set;
      if (wr_en && address == 3'd2) irq_mask <= writedata[WIDTH-1:0];
      if (wr_en && address == 3'd4) rise_en  <= writedata[WIDTH-1:0];
      if (wr_en && address == 3'd5) fall_en  <= writedata[WIDTH-1:0];
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_system_acl_iface_dbnc_pio.sv
// tb/tb_system_acl_iface_dbnc_pio.sv - self-checking bench for system_acl_iface_dbnc_pio
module tb_system_acl_iface_dbnc_pio;

  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  system_acl_iface_dbnc_pio #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // Reference model: sync_in is the input seen S edges earlier; a bit of db
  // flips when the last D presented samples all disagree with it.
  logic [W-1:0] m_pipe [S];
  logic [W-1:0] m_seen [$];
  logic [W-1:0] m_db, m_mask, m_ec, m_rise, m_fall;
  logic [31:0]  m_rd;

  function automatic logic m_irq();
    return |(m_ec & m_mask);
  endfunction

  task automatic model_step();
    logic [W-1:0] nd, set, clr;
    logic all_diff;
    if (!reset_n) begin
      for (int k = 0; k < S; k++) m_pipe[k] = '0;
      m_seen.delete();
      m_db = '0; m_mask = '0; m_ec = '0; m_rise = '1; m_fall = '1; m_rd = '0;
    end else begin
      case (address)
        3'd0: m_rd = 32'(m_db);
        3'd1: m_rd = 32'(m_pipe[S-1]);
        3'd2: m_rd = 32'(m_mask);
        3'd3: m_rd = 32'(m_ec);
        3'd4: m_rd = 32'(m_rise);
        3'd5: m_rd = 32'(m_fall);
        default: m_rd = 32'd0;
      endcase
      m_seen.push_back(m_pipe[S-1]);
      if (m_seen.size() > D) void'(m_seen.pop_front());
      nd = m_db;
      for (int i = 0; i < W; i++) begin
        if (m_seen.size() == D) begin
          all_diff = 1'b1;
          foreach (m_seen[j]) if (m_seen[j][i] == m_db[i]) all_diff = 1'b0;
          if (all_diff) nd[i] = ~m_db[i];
        end
      end
      set = (nd & ~m_db & m_rise) | (~nd & m_db & m_fall);
      clr = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
      m_ec = (m_ec & ~clr) | set;
      if (chipselect && !write_n) begin
        if (address == 3'd2) m_mask = writedata[W-1:0];
        if (address == 3'd4) m_rise = writedata[W-1:0];
        if (address == 3'd5) m_fall = writedata[W-1:0];
      end
      m_db = nd;
      for (int k = S-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = in_port;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    ticks(3);
    vectors++;
    if (readdata !== 32'd0) begin miscompares++; $display("FAIL reset_readdata got %h want 0", readdata); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
    reset_n = 1'b1; address = 3'd4;
    tick();
    vectors++;
    if (readdata !== 32'hF || readdata !== m_rd) begin miscompares++; $display("FAIL reset_rise_en got %h want f", readdata); end
    address = 3'd5;
    tick();
    vectors++;
    if (readdata !== 32'hF) begin miscompares++; $display("FAIL reset_fall_en got %h want f", readdata); end
    address = 3'd3;
    ticks(8);
    vectors++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin miscompares++; $display("FAIL reset_idle_capture got %h/%b want 0/0", readdata, irq); end
  endtask

  task automatic test_latency();
    address = 3'd3;
    in_port = 4'h1;
    ticks(6);
    vectors++;
    if (readdata !== 32'd0) begin miscompares++; $display("FAIL latency_edge6 got %h want 0", readdata); end
    tick();
    vectors++;
    if (readdata !== 32'h1 || readdata !== m_rd) begin miscompares++; $display("FAIL latency_edge7 got %h want 1", readdata); end
    address = 3'd0;
    tick();
    vectors++;
    if (readdata !== 32'h1) begin miscompares++; $display("FAIL latency_db got %h want 1", readdata); end
  endtask

  task automatic test_glitch();
    bus_write(3'd3, 32'hF);
    address = 3'd3;
    for (int e = 1; e <= 12; e++) begin
      in_port[1] = (e <= 3);
      tick();
      vectors++;
      if (readdata !== m_rd) begin miscompares++; $display("FAIL glitch3_cycle%0d got %h want %h", e, readdata, m_rd); end
    end
    vectors++;
    if (readdata !== 32'd0) begin miscompares++; $display("FAIL glitch3_capture got %h want 0", readdata); end
    for (int e = 1; e <= 14; e++) begin
      in_port[1] = (e <= 4);
      if (e == 7) begin chipselect = 1'b1; write_n = 1'b0; writedata = 32'h2; end
      tick();
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      vectors++;
      if (readdata !== m_rd) begin miscompares++; $display("FAIL pulse4_cycle%0d got %h want %h", e, readdata, m_rd); end
      if (e == 7 || e == 9 || e == 11) begin
        vectors++;
        if (readdata !== ((e == 9) ? 32'd0 : 32'h2)) begin
          miscompares++; $display("FAIL pulse4_edge%0d got %h want %h", e, readdata, (e == 9) ? 32'd0 : 32'h2);
        end
      end
    end
  endtask

  task automatic test_irq();
    bus_write(3'd2, 32'h1);
    bus_write(3'd4, 32'h1);
    bus_write(3'd5, 32'h0);
    in_port = 4'h0;
    ticks(10);
    bus_write(3'd3, 32'hF);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_idle got %b want 0", irq); end
    in_port = 4'h1;
    ticks(8);
    vectors++;
    if (irq !== 1'b1 || irq !== m_irq()) begin miscompares++; $display("FAIL irq_rise got %b want 1", irq); end
    bus_write(3'd3, 32'h1);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear got %b want 0", irq); end
    in_port = 4'h0;
    address = 3'd3;
    ticks(10);
    vectors++;
    if (irq !== 1'b0 || readdata !== 32'd0) begin miscompares++; $display("FAIL irq_fall got %b/%h want 0/0", irq, readdata); end
  endtask

  task automatic test_set_wins();
    bus_write(3'd4, 32'hF);
    bus_write(3'd5, 32'hF);
    in_port = 4'h4;
    ticks(5);
    address = 3'd3; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    tick();
    vectors++;
    if (readdata !== 32'h4 || readdata !== m_rd) begin miscompares++; $display("FAIL set_wins got %h want 4", readdata); end
  endtask

  task automatic test_reset_mid();
    in_port = 4'hF;
    ticks(4);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    vectors++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin miscompares++; $display("FAIL midreset_regs got %h/%b want 0/0", readdata, irq); end
    address = 3'd3;
    ticks(6);
    vectors++;
    if (readdata !== 32'd0) begin miscompares++; $display("FAIL midreset_edge6 got %h want 0", readdata); end
    tick();
    vectors++;
    if (readdata !== 32'hF || readdata !== m_rd) begin miscompares++; $display("FAIL midreset_edge7 got %h want f", readdata); end
    address = 3'd4;
    tick();
    vectors++;
    if (readdata !== 32'hF) begin miscompares++; $display("FAIL midreset_rise got %h want f", readdata); end
    address = 3'd5;
    tick();
    vectors++;
    if (readdata !== 32'hF) begin miscompares++; $display("FAIL midreset_fall got %h want f", readdata); end
  endtask

  task automatic test_ignored_writes();
    bus_write(3'd0, 32'hFF);
    bus_write(3'd1, 32'hFF);
    in_port = 4'h0;
    address = 3'd0;
    tick();
    vectors++;
    if (readdata !== 32'hF) begin miscompares++; $display("FAIL ro_db got %h want f", readdata); end
    address = 3'd6;
    tick();
    vectors++;
    if (readdata !== 32'd0) begin miscompares++; $display("FAIL addr6 got %h want 0", readdata); end
    bus_write(3'd7, 32'hFF);
    vectors++;
    if (readdata !== 32'd0) begin miscompares++; $display("FAIL addr7 got %h want 0", readdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
      address = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
      end else begin
        chipselect = $urandom_range(0, 1) == 1; write_n = 1'b1; writedata = $urandom;
      end
      tick();
      vectors++;
      if (readdata !== m_rd) begin miscompares++; $display("FAIL random_rd%0d got %h want %h", n, readdata, m_rd); end
      vectors++;
      if (irq !== m_irq()) begin miscompares++; $display("FAIL random_irq%0d got %b want %b", n, irq, m_irq()); end
    end
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_irq();
    test_set_wins();
    test_reset_mid();
    test_ignored_writes();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/system_acl_iface_dbnc_pio.md
SYSTEM_ACL_IFACE_DBNC_PIO -- requirements
Module: system_acl_iface_dbnc_pio

Interface
REQ-001 Parameter WIDTH, default 4: number of input bits, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth, legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000: consecutive stable cycles required before a bit change is accepted, legal range 1..65535; counter width = clog2(DEBOUNCE_CYCLES+1).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 address  input  3  Avalon slave word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous raw inputs (switches/buttons).
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  level interrupt.

Function
REQ-013 in_port SHALL pass through SYNC_STAGES flops; the last stage is sync_in.
REQ-014 Per bit, a debounced state db and counter cnt SHALL exist; when sync_in!=db, cnt increments; when sync_in==db, cnt clears to 0.
REQ-015 When sync_in!=db and cnt==DEBOUNCE_CYCLES-1, db SHALL take sync_in on that edge and cnt clears; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change db.
REQ-016 Latency: a clean in_port step SHALL reach db exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges after first sampling.
REQ-017 A 0->1 db update on bit i with rise_en[i]=1, or a 1->0 db update with fall_en[i]=1, SHALL set edge_capture[i] on the same edge db updates.
REQ-018 Register map (read): 0 db; 1 sync_in; 2 irq_mask; 3 edge_capture; 4 rise_en; 5 fall_en; 6-7 read 0; unused upper bits read 0.
REQ-019 Writes occur when chipselect=1 and write_n=0: addr 2 loads irq_mask, addr 4 loads rise_en, addr 5 loads fall_en, each from writedata[WIDTH-1:0]; writes to 0, 1, 6, 7 SHALL be ignored.
REQ-020 Write to addr 3 SHALL clear each edge_capture bit whose writedata bit is 1 (write-1-to-clear); 0 bits unaffected.
REQ-021 Simultaneous clear and set on the same bit in the same cycle: set SHALL win (bit remains 1).
REQ-022 readdata SHALL be registered every cycle from the mux on the current address, independent of chipselect: one-cycle read latency, no wait states.
REQ-023 irq SHALL equal OR-reduce(edge_capture & irq_mask), combinational from registers, asserted the same edge edge_capture sets.
REQ-024 Changing rise_en/fall_en SHALL NOT set or clear existing edge_capture bits.

Reset
REQ-025 On a clk edge with reset_n=0: synchronizer flops, db, cnt, irq_mask, edge_capture, readdata SHALL be 0; rise_en and fall_en SHALL be all ones (any-edge mode).
REQ-026 Reset asserted mid-debounce SHALL discard the pending count; no edge_capture set on release from an in_port already high until DEBOUNCE_CYCLES stable cycles elapse after sync.
REQ-027 irq SHALL be 0 during and immediately after reset.

Verification (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-028 in_port 0x0->0x1 held -> db[0]=1 and edge_capture=0x1 at edge 6; read addr 3 -> readdata=0x1 one cycle later.
REQ-029 in_port[1] pulsed high 3 cycles -> db, edge_capture unchanged; a 4-cycle pulse -> edge_capture[1] set on rise and again after clear on fall.
REQ-030 irq_mask=0x1, rise_en=0x1, fall_en=0x0; toggle bit0 up then down -> irq=1 after rise only; write 0x1 to addr 3 -> irq=0 next cycle, stays 0 after fall.
REQ-031 Write 0x4 to addr 3 on the same edge bit2 db update sets capture -> edge_capture[2]=1 after the edge.
REQ-032 Hold in_port=0xF, pulse reset_n low 1 cycle at count 2 -> all regs reset, rise_en=fall_en=0xF, edge_capture=0xF exactly 6 edges after release.
REQ-033 Write 0xFF to addr 0 and 1, read addr 6 -> db unchanged, readdata=0 for addr 6.
